// File: rtl/inst_rom_loader_if.sv
// Fetch port and byte-stream load port of the instruction ROM loader.
// master = core/program source side, slave = loader side.
interface inst_rom_loader_if;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_last;
    logic        ld_ready;

    modport master (
        output rom_ce, rom_addr, ld_valid, ld_data, ld_last,
        input  rom_data, ld_ready
    );

    modport slave (
        input  rom_ce, rom_addr, ld_valid, ld_data, ld_last,
        output rom_data, ld_ready
    );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM loader: packs a big-endian byte stream into word storage,
// then releases the core (cpu_run) and serves fetches combinationally.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_INIT | one-cycle settle after reset, bytes ignored
// S_LOAD | accepting program bytes, fetches return NOP
// S_RUN  | load complete, core released, serving fetches until reset
module inst_rom_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_rom_loader_if.slave      bus,
    output logic                  cpu_run,
    output logic                  ld_err,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;
    logic [1:0]              byte_idx;
    logic [31:0]             pack;
    logic [31:0]             word_nxt;
    logic                    accept;
    logic                    word_done;
    logic                    full;
    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   word_addr;
    logic                    addr_hi_zero;
    logic                    addr_in_range;
    logic                    addr_unused;
    logic [31:0]             mem [0:DEPTH-1];

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_INIT;
        else      state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_INIT:  state_nxt = S_LOAD;
            S_LOAD:  if (accept && bus.ld_last) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_INIT;
        endcase
    end

    // Outputs decoded from the state register only.
    always_comb begin
        bus.ld_ready = 1'b0;
        cpu_run      = 1'b0;
        unique case (state)
            S_LOAD:  bus.ld_ready = 1'b1;
            S_RUN:   cpu_run      = 1'b1;
            default: ;
        endcase
    end

    assign accept    = bus.ld_valid && bus.ld_ready;
    assign word_done = accept && ((byte_idx == 2'd3) || bus.ld_last);
    assign full      = (word_count == DEPTH_W);
    assign mem_we    = word_done && !full;

    // Merge the incoming byte into its lane; lanes below stay zero because
    // pack is cleared at every word boundary, which gives the flush padding.
    always_comb begin
        word_nxt = pack;
        unique case (byte_idx)
            2'd0: word_nxt[31:24] = bus.ld_data;
            2'd1: word_nxt[23:16] = bus.ld_data;
            2'd2: word_nxt[15:8]  = bus.ld_data;
            2'd3: word_nxt[7:0]   = bus.ld_data;
            default: ;
        endcase
    end

    // Packing, word counter and sticky overflow flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx   <= 2'd0;
            pack       <= 32'd0;
            word_count <= '0;
            ld_err     <= 1'b0;
        end else if (accept) begin
            if (word_done) begin
                byte_idx <= 2'd0;
                pack     <= 32'd0;
                if (full) ld_err     <= 1'b1;
                else      word_count <= word_count + 1'b1;
            end else begin
                byte_idx <= byte_idx + 2'd1;
                pack     <= word_nxt;
            end
        end
    end

    // Word storage write; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[word_count[ADDR_WIDTH-1:0]] <= word_nxt;
    end

    assign word_addr     = bus.rom_addr[ADDR_WIDTH+1:2];
    assign addr_hi_zero  = (bus.rom_addr[31:ADDR_WIDTH+2] == '0);
    assign addr_in_range = ({1'b0, word_addr} < word_count);
    assign addr_unused   = &{1'b0, bus.rom_addr[1:0]};

    // Combinational fetch; anything not a valid loaded word reads as NOP (0).
    always_comb begin
        bus.rom_data = 32'd0;
        if (cpu_run && bus.rom_ce && addr_hi_zero && addr_in_range)
            bus.rom_data = mem[word_addr];
    end
endmodule

// File: tb/tb_inst_rom_loader.sv
// Self-checking bench for inst_rom_loader: directed program loads plus
// randomized gapped loads, checked against a byte-queue reference model.
module tb_inst_rom_loader;
    logic clk = 1'b0;
    logic rst;
    logic rst_b;
    always #5 clk = ~clk;

    inst_rom_loader_if bus_a();
    inst_rom_loader_if bus_b();

    logic        run_a, err_a;
    logic [10:0] wc_a;
    logic        run_b, err_b;
    logic [2:0]  wc_b;

    inst_rom_loader #(.ADDR_WIDTH(10)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a),
        .cpu_run(run_a), .ld_err(err_a), .word_count(wc_a)
    );

    inst_rom_loader #(.ADDR_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst_b), .bus(bus_b),
        .cpu_run(run_b), .ld_err(err_b), .word_count(wc_b)
    );

    int n_chk  = 0;
    int n_fail = 0;
    logic [7:0] acc[$];
    logic [7:0] acc_b[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: word i holds bytes 4i..4i+3 big-endian, missing bytes are zero.
    function automatic logic [31:0] model_word(input logic [7:0] q[$], input int i);
        logic [31:0] w = 32'd0;
        for (int k = 0; k < 4; k++)
            if (4 * i + k < q.size()) w |= 32'(q[4 * i + k]) << (24 - 8 * k);
        return w;
    endfunction

    function automatic int model_count(input logic [7:0] q[$], input int aw);
        int nw = (q.size() + 3) / 4;
        return (nw > (1 << aw)) ? (1 << aw) : nw;
    endfunction

    function automatic logic [31:0] model_fetch(input logic [7:0] q[$], input int aw,
                                                input logic [31:0] addr, input bit ce, input bit run);
        longint idx = longint'(addr) / 4;
        if (!ce || !run) return 32'd0;
        if (idx >= model_count(q, aw)) return 32'd0;
        return model_word(q, int'(idx));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        bus_a.ld_valid = 1'b0; bus_a.ld_last = 1'b0;
        bus_a.rom_ce = 1'b1;   bus_a.rom_addr = 32'd0;
        #1;
        chk("rst_ready", bus_a.ld_ready, 0);
        chk("rst_run",   run_a, 0);
        chk("rst_wc",    wc_a, 0);
        chk("rst_err",   err_a, 0);
        chk("rst_rom",   bus_a.rom_data, 0);
        repeat (2) @(negedge clk);
        // A byte (even flagged last) offered in the INIT cycle must be dropped.
        bus_a.ld_valid = 1'b1; bus_a.ld_data = 8'hEE; bus_a.ld_last = 1'b1;
        rst = 1'b1;
        #1 chk("init_ready", bus_a.ld_ready, 0);
        @(posedge clk); #1;
        bus_a.ld_valid = 1'b0; bus_a.ld_last = 1'b0;
        chk("load_ready",   bus_a.ld_ready, 1);
        chk("init_drop_wc", wc_a, 0);
        chk("init_drop_run", run_a, 0);
        acc.delete();
    endtask

    task automatic send_byte(input logic [7:0] d, input bit last, input int gap);
        int budget;
        for (int g = 0; g < gap; g++) begin
            bus_a.ld_valid = 1'b0;
            bus_a.ld_last  = ($urandom_range(0, 2) == 0);
            bus_a.ld_data  = 8'($urandom);
            @(negedge clk);
            chk("gap_no_run", run_a, 0);
            @(posedge clk); #1;
        end
        bus_a.ld_valid = 1'b1; bus_a.ld_data = d; bus_a.ld_last = last;
        budget = 8;
        @(negedge clk);
        while (!bus_a.ld_ready && budget > 0) begin
            @(posedge clk); #1;
            @(negedge clk);
            budget--;
        end
        if (budget == 0) chk("ready_timeout", 0, 1);
        bus_a.rom_ce   = 1'b1;
        bus_a.rom_addr = 32'($urandom_range(0, 63));
        #1;
        chk("load_fetch_nop", bus_a.rom_data, 0);
        chk("load_no_run", run_a, 0);
        @(posedge clk); #1;
        bus_a.ld_valid = 1'b0; bus_a.ld_last = 1'b0;
        acc.push_back(d);
    endtask

    task automatic load_a(input logic [7:0] bytes[$], input bit gaps);
        foreach (bytes[i])
            send_byte(bytes[i], i == bytes.size() - 1, gaps ? int'($urandom_range(0, 3)) : 0);
    endtask

    task automatic fetch_a(input string tag, input bit ce, input logic [31:0] addr,
                           input logic [31:0] exp);
        @(negedge clk);
        bus_a.rom_ce = ce; bus_a.rom_addr = addr;
        #1 chk(tag, bus_a.rom_data, 64'(exp));
        @(posedge clk); #1;
    endtask

    task automatic check_load_a(input string tag);
        int n;
        logic [31:0] a;
        bit ce;
        n = model_count(acc, 10);
        @(negedge clk);
        chk({tag, "_run"}, run_a, 1);
        chk({tag, "_wc"},  wc_a, 64'(n));
        chk({tag, "_err"}, err_a, 0);
        @(posedge clk); #1;
        for (int i = 0; i <= n; i++) begin
            a = 32'(i * 4 + int'($urandom_range(0, 3)));
            fetch_a({tag, "_fetch"}, 1'b1, a, model_fetch(acc, 10, a, 1'b1, 1'b1));
        end
        repeat (6) begin
            a  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 2) == 0) a |= 32'h1 << $urandom_range(12, 31);
            ce = 1'($urandom_range(0, 1));
            fetch_a({tag, "_rfetch"}, ce, a, model_fetch(acc, 10, a, ce, 1'b1));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        int len;

        rst = 1'b0; rst_b = 1'b0;
        bus_a.rom_ce = 1'b0; bus_a.rom_addr = 32'd0;
        bus_a.ld_valid = 1'b0; bus_a.ld_data = 8'd0; bus_a.ld_last = 1'b0;
        bus_b.rom_ce = 1'b0; bus_b.rom_addr = 32'd0;
        bus_b.ld_valid = 1'b0; bus_b.ld_data = 8'd0; bus_b.ld_last = 1'b0;

        // Eight bytes, two full words.
        do_reset();
        q = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        load_a(q, 1'b0);
        check_load_a("t1");
        chk("t1_wc2", wc_a, 2);
        fetch_a("t1_a0",   1'b1, 32'h0, 32'h12345678);
        fetch_a("t1_a4",   1'b1, 32'h4, 32'h9ABCDEF0);
        fetch_a("t1_a8",   1'b1, 32'h8, 32'h00000000);
        fetch_a("t1_a6",   1'b1, 32'h6, 32'h9ABCDEF0);
        fetch_a("t3_ce0",  1'b0, 32'h0, 32'h00000000);
        fetch_a("t3_hi",   1'b1, 32'h80000000, 32'h00000000);

        // Five bytes: final word flushed with zero padding.
        do_reset();
        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        load_a(q, 1'b0);
        check_load_a("t2");
        chk("t2_wc2", wc_a, 2);
        fetch_a("t2_a0", 1'b1, 32'h0, 32'h01020304);
        fetch_a("t2_a4", 1'b1, 32'h4, 32'h05000000);

        // Random programs with random gaps and stray ld_last pulses.
        repeat (6) begin
            do_reset();
            q.delete();
            len = int'($urandom_range(1, 40));
            for (int i = 0; i < len; i++) q.push_back(8'($urandom));
            load_a(q, 1'b1);
            check_load_a("rnd");
        end

        // Asynchronous reset in the middle of a load, then a fresh load.
        do_reset();
        for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1'b0, 0);
        #2 rst = 1'b0;
        #1;
        chk("t6_ready", bus_a.ld_ready, 0);
        chk("t6_run",   run_a, 0);
        chk("t6_wc",    wc_a, 0);
        chk("t6_err",   err_a, 0);
        do_reset();
        q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load_a(q, 1'b0);
        check_load_a("t6");
        fetch_a("t6_a0", 1'b1, 32'h0, 32'hAABBCCDD);
        fetch_a("t6_a4", 1'b1, 32'h4, 32'h00000000);

        // Overflow on a 4-word store: 20 bytes, fifth word dropped.
        @(negedge clk);
        rst_b = 1'b1;
        @(posedge clk); #1;
        acc_b.delete();
        for (int i = 0; i < 20; i++) begin
            bus_b.ld_valid = 1'b1;
            bus_b.ld_data  = 8'($urandom);
            bus_b.ld_last  = (i == 19);
            @(negedge clk);
            chk("t4_ready", bus_b.ld_ready, 1);
            @(posedge clk); #1;
            acc_b.push_back(bus_b.ld_data);
            bus_b.ld_valid = 1'b0; bus_b.ld_last = 1'b0;
            if (i == 15) begin
                chk("t4_wc_full", wc_b, 4);
                chk("t4_err_pre", err_b, 0);
            end
            if (i == 18) chk("t4_err_b19", err_b, 0);
        end
        @(negedge clk);
        chk("t4_err",  err_b, 1);
        chk("t4_wc",   wc_b, 4);
        chk("t4_run",  run_b, 1);
        bus_b.ld_valid = 1'b1; bus_b.ld_last = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus_b.ld_valid = 1'b0; bus_b.ld_last = 1'b0;
        @(negedge clk);
        chk("t4_err_sticky", err_b, 1);
        chk("t4_wc_hold",    wc_b, 4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus_b.rom_ce   = 1'b1;
            bus_b.rom_addr = 32'(i * 4 + int'($urandom_range(0, 3)));
            #1 chk("t4_fetch", bus_b.rom_data,
                   64'(model_fetch(acc_b, 2, bus_b.rom_addr, 1'b1, 1'b1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
